mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning byte-address width of every address port.
REQ-002 SHALL have parameter FAIR_LIMIT, default 3, meaning the number of consecutive MEM grants allowed while IF waits (used only with ARB_FAIR_EN).
REQ-003 SHALL have ports Clk in 1 (the clock) and Clr in 1 (the reset), with one clock; reset is asynchronous and active-low.
REQ-004 SHALL have the IF requester ports: if_req in 1 (fetch request), if_addr in ADDR_W (fetch address), if_data out 32 (fetched word), if_ack out 1 (access done), if_stall out 1 (freeze PC/IF-ID).
REQ-005 SHALL have the MEM requester ports: mem_req in 1, mem_addr in ADDR_W, mem_wdata in 32, mem_rw in 1 (1=store), mem_size in 1 (1=byte), mem_rdata out 32, mem_ack out 1, mem_stall out 1 (freeze EX-MEM and earlier).
REQ-006 SHALL have the shared port: p_en out 1, p_addr out ADDR_W, p_wdata out 32, p_rw out 1, p_size out 1, p_rdata in 32, p_rdy in 1 (access complete this cycle).

Function
REQ-007 SHALL implement FSM states IDLE, GNT_IF and GNT_MEM, held in a registered state variable.
REQ-008 In IDLE with mem_req=1, next state SHALL be GNT_MEM; else with if_req=1, GNT_IF; else IDLE (strict MEM priority unless REQ-016 applies).
REQ-009 On the edge entering GNT_x, the arbiter SHALL latch that requester's addr/wdata/rw/size into port registers; p_* outputs SHALL come only from these registers.
REQ-010 p_en SHALL be 1 exactly in GNT_IF and GNT_MEM; in GNT_IF, p_rw=0 and p_size=0 (word read).
REQ-011 x_ack SHALL be combinational: (state==GNT_x) & p_rdy & x_req; x_data/mem_rdata SHALL pass p_rdata through in that cycle and hold 0 otherwise.
REQ-012 When p_rdy=1 in GNT_x, next state SHALL be IDLE; when p_rdy=0, the state SHALL be held indefinitely (no timeout).
REQ-013 Latency SHALL be minimum 1 cycle from the IDLE arbitration cycle to ack; throughput SHALL be at most one access per 2 cycles (mandatory IDLE between grants).
REQ-014 x_stall SHALL equal x_req & ~x_ack, combinationally.
REQ-015 If x_req drops during GNT_x, the port access SHALL complete, and no ack SHALL issue for it.
REQ-016 With ARB_FAIR_EN, when the fairness counter equals FAIR_LIMIT and if_req=1 in IDLE, the arbiter SHALL grant IF regardless of mem_req.

Reset
REQ-017 Clr=0 SHALL asynchronously force state=IDLE, all port registers=0, and the fairness counter=0; consequently p_en=0, both acks=0, and both data outputs=0.
REQ-018 A reset asserted mid-grant SHALL abort the access with no ack; after release, pending requests SHALL be rearbitrated from IDLE.

Configuration
REQ-019 With macro ARB_FAIR_EN defined, the design SHALL include a counter of width clog2(FAIR_LIMIT+1) that increments on each MEM grant made while if_req=1, saturates at FAIR_LIMIT, and clears on any IF grant or on an arbitration cycle with if_req=0.
REQ-020 Without ARB_FAIR_EN, the design SHALL have no counter and SHALL use strict MEM priority (IF may starve).

Structure
REQ-021 State encodings (IDLE=2'b00, GNT_IF=2'b01, GNT_MEM=2'b10) and the FAIR_LIMIT default SHALL reside in the shared package ppu_pkg.
REQ-022 The fairness counter SHALL be the sub-module arb_fair_counter, instantiated only under ARB_FAIR_EN.

Verification
REQ-023 The bench SHALL check: if_req=1 with if_addr=8'h10, p_rdy=1 one cycle after grant -> p_addr=8'h10, p_rw=0, if_ack for one cycle with if_data=p_rdata, and if_stall=0 in that cycle.
REQ-024 The bench SHALL check: if_req and mem_req both high, with mem_rw=1, mem_addr=8'h20 and mem_wdata=32'hDEADBEEF -> GNT_MEM first with p_wdata=32'hDEADBEEF, then IDLE, then GNT_IF; if_stall=1 throughout.
REQ-025 The bench SHALL check: p_rdy held 0 for 5 cycles in GNT_MEM -> p_en held and mem_stall=1 for 5 cycles, with ack only on the 6th cycle.
REQ-026 The bench SHALL check, with ARB_FAIR_EN and FAIR_LIMIT=3: mem_req continuously high and if_req high -> the grant pattern MEM,MEM,MEM,IF repeats; without the macro, no IF grant ever occurs.
REQ-027 The bench SHALL check: Clr=0 pulsed mid-GNT_MEM -> p_en=0 immediately with no ack; after release, a still-high mem_req is regranted within 2 cycles.
REQ-028 The bench SHALL check: mem_req dropped during GNT_MEM, then p_rdy=1 -> mem_ack=0 and state returns to IDLE.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared types and constants for the memory-port arbiter.
package ppu_pkg;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned FAIR_LIMIT_DEF = 3;

  // Arbiter state encoding
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GNT_IF  = 2'b01,
    GNT_MEM = 2'b10
  } arb_state_e;

  // Latched command for the shared port (address is kept separately since its width is a parameter)
  typedef struct packed {
    logic [DATA_W-1:0] wdata;
    logic              rw;
    logic              size;
  } port_cmd_t;

  // True in either grant state
  function automatic logic is_grant(input arb_state_e s);
    return (s == GNT_IF) || (s == GNT_MEM);
  endfunction

endpackage

// File: rtl/arb_fair_counter.sv
// Saturating count of consecutive MEM grants made while IF was waiting.
module arb_fair_counter
  import ppu_pkg::*;
#(
  parameter int unsigned LIMIT = FAIR_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_limit_c
);

  localparam int unsigned CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [CNT_W-1:0] r_cnt;

  // Clear wins; increment saturates at LIMIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != CNT_W'(LIMIT))) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_at_limit_c = (r_cnt == CNT_W'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (instruction fetch / data memory) arbiter for one shared memory port.
// MEM has strict priority; define ARB_FAIR_EN to force an IF grant after
// FAIR_LIMIT back-to-back MEM grants while IF is waiting.
module mem_port_arbiter
  import ppu_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned FAIR_LIMIT = FAIR_LIMIT_DEF
) (
  input  logic              Clk,
  input  logic              Clr,
  // instruction fetch requester
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_data,
  output logic              if_ack,
  output logic              if_stall,
  // data memory requester
  input  logic              mem_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic              mem_rw,
  input  logic              mem_size,
  output logic [31:0]       mem_rdata,
  output logic              mem_ack,
  output logic              mem_stall,
  // shared port
  output logic              p_en,
  output logic [ADDR_W-1:0] p_addr,
  output logic [31:0]       p_wdata,
  output logic              p_rw,
  output logic              p_size,
  input  logic [31:0]       p_rdata,
  input  logic              p_rdy
);

  arb_state_e        r_state;
  arb_state_e        w_next;
  logic [ADDR_W-1:0] r_addr;
  port_cmd_t         r_cmd;

  logic w_arb;
  logic w_gnt_if;
  logic w_gnt_mem;
  logic w_fair_force;

  // IDLE is the arbitration cycle; a grant is the transition out of it
  assign w_arb     = (r_state == IDLE);
  assign w_gnt_if  = w_arb & (w_next == GNT_IF);
  assign w_gnt_mem = w_arb & (w_next == GNT_MEM);

`ifdef ARB_FAIR_EN
  logic w_at_limit;

  arb_fair_counter #(
    .LIMIT(FAIR_LIMIT)
  ) u_fair (
    .clk          (Clk),
    .rst_n        (Clr),
    .i_inc        (w_gnt_mem & if_req),
    .i_clr        (w_gnt_if | (w_arb & ~if_req)),
    .o_at_limit_c (w_at_limit)
  );

  assign w_fair_force = w_at_limit & if_req;
`else
  logic w_unused_fair;

  assign w_unused_fair = ^FAIR_LIMIT;
  assign w_fair_force  = 1'b0;
`endif

  // State register
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: arbitrate in IDLE, hold a grant until the port reports ready
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_fair_force) begin
          w_next = GNT_IF;
        end else if (mem_req) begin
          w_next = GNT_MEM;
        end else if (if_req) begin
          w_next = GNT_IF;
        end
      end
      GNT_IF, GNT_MEM: begin
        if (p_rdy) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Capture the winner's command on the grant edge; IF is always a word read
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      r_addr <= '0;
      r_cmd  <= '0;
    end else if (w_gnt_mem) begin
      r_addr <= mem_addr;
      r_cmd  <= '{wdata: mem_wdata, rw: mem_rw, size: mem_size};
    end else if (w_gnt_if) begin
      r_addr <= if_addr;
      r_cmd  <= '{wdata: 32'h0, rw: 1'b0, size: 1'b0};
    end
  end

  assign p_en    = is_grant(r_state);
  assign p_addr  = r_addr;
  assign p_wdata = r_cmd.wdata;
  assign p_rw    = r_cmd.rw;
  assign p_size  = r_cmd.size;

  // Completion handshakes; a requester that withdrew gets no ack
  assign if_ack    = (r_state == GNT_IF)  & p_rdy & if_req;
  assign mem_ack   = (r_state == GNT_MEM) & p_rdy & mem_req;
  assign if_data   = if_ack  ? p_rdata : 32'h0;
  assign mem_rdata = mem_ack ? p_rdata : 32'h0;
  assign if_stall  = if_req  & ~if_ack;
  assign mem_stall = mem_req & ~mem_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic
// checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned FL = 3;

  logic          Clk = 1'b0;
  logic          Clr;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_data;
  logic          if_ack;
  logic          if_stall;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_rw;
  logic          mem_size;
  logic [31:0]   mem_rdata;
  logic          mem_ack;
  logic          mem_stall;
  logic          p_en;
  logic [AW-1:0] p_addr;
  logic [31:0]   p_wdata;
  logic          p_rw;
  logic          p_size;
  logic [31:0]   p_rdata;
  logic          p_rdy;

  int n_checks = 0;
  int n_errors = 0;

  // model: who owns the port (0 none, 1 IF, 2 MEM) and the command it was given
  int            m_own;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic          m_rw;
  logic          m_size;
`ifdef ARB_FAIR_EN
  int            m_run;
`endif

  int gq[$];

  mem_port_arbiter #(.ADDR_W(AW), .FAIR_LIMIT(FL)) dut (
    .Clk(Clk), .Clr(Clr),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_ack(if_ack), .if_stall(if_stall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw),
    .mem_size(mem_size), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_stall(mem_stall),
    .p_en(p_en), .p_addr(p_addr), .p_wdata(p_wdata), .p_rw(p_rw), .p_size(p_size),
    .p_rdata(p_rdata), .p_rdy(p_rdy)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own   = 0;
    m_addr  = '0;
    m_wdata = '0;
    m_rw    = 1'b0;
    m_size  = 1'b0;
`ifdef ARB_FAIR_EN
    m_run   = 0;
`endif
  endtask

  task automatic model_check();
    logic e_ia;
    logic e_ma;
    e_ia = (m_own == 1) && p_rdy && if_req;
    e_ma = (m_own == 2) && p_rdy && mem_req;
    check_eq("p_en",      p_en, m_own != 0);
    check_eq("p_addr",    p_addr, m_addr);
    check_eq("p_wdata",   p_wdata, m_wdata);
    check_eq("p_rw_size", {p_rw, p_size}, {m_rw, m_size});
    check_eq("if_ack",    if_ack, e_ia);
    check_eq("mem_ack",   mem_ack, e_ma);
    check_eq("if_data",   if_data, e_ia ? p_rdata : 32'h0);
    check_eq("mem_rdata", mem_rdata, e_ma ? p_rdata : 32'h0);
    check_eq("if_stall",  if_stall, if_req & ~e_ia);
    check_eq("mem_stall", mem_stall, mem_req & ~e_ma);
  endtask

  // One clock of arbitration rules applied to the inputs seen this cycle
  task automatic model_advance();
    int g;
    bit force_if;
    g = 0;
    force_if = 1'b0;
    if (!Clr) begin
      model_reset();
      return;
    end
    if (m_own == 0) begin
`ifdef ARB_FAIR_EN
      force_if = if_req && (m_run == int'(FL));
`endif
      if (force_if) g = 1;
      else if (mem_req) g = 2;
      else if (if_req) g = 1;
      if (g == 2) begin
        m_addr = mem_addr; m_wdata = mem_wdata; m_rw = mem_rw; m_size = mem_size;
      end else if (g == 1) begin
        m_addr = if_addr; m_wdata = 32'h0; m_rw = 1'b0; m_size = 1'b0;
      end
`ifdef ARB_FAIR_EN
      if (g == 1 || !if_req) m_run = 0;
      else if (g == 2 && m_run < int'(FL)) m_run++;
`endif
      m_own = g;
    end else if (p_rdy) begin
      m_own = 0;
    end
  endtask

  task automatic settle();
    @(negedge Clk);
    if (!Clr) model_reset();
    model_check();
  endtask

  task automatic advance();
    model_advance();
    @(posedge Clk);
    #1;
  endtask

  task automatic cyc();
    settle();
    advance();
  endtask

  initial begin
    Clr = 1'b0; if_req = 0; if_addr = '0; mem_req = 0; mem_addr = '0; mem_wdata = '0;
    mem_rw = 0; mem_size = 0; p_rdata = '0; p_rdy = 0;
    model_reset();

    // reset state
    p_rdy = 1'b1; mem_req = 1'b1; if_req = 1'b1; p_rdata = 32'h1234_5678;
    settle();
    check_eq("rst_p_en", p_en, 1'b0);
    check_eq("rst_acks", {if_ack, mem_ack}, 2'b00);
    check_eq("rst_data", {if_data, mem_rdata}, 64'h0);
    advance();
    mem_req = 0; if_req = 0; p_rdy = 0;
    Clr = 1'b1;

    // single IF fetch, ready one cycle after grant
    if_req = 1; if_addr = 8'h10;
    settle();
    check_eq("a_idle_stall", if_stall, 1'b1);
    advance();
    p_rdy = 1; p_rdata = $urandom;
    settle();
    check_eq("a_p_addr", p_addr, 8'h10);
    check_eq("a_p_rw", p_rw, 1'b0);
    check_eq("a_if_ack", if_ack, 1'b1);
    check_eq("a_if_data", if_data, p_rdata);
    check_eq("a_if_stall", if_stall, 1'b0);
    advance();
    if_req = 0; p_rdy = 0;
    settle();
    check_eq("a_ack_once", if_ack, 1'b0);
    check_eq("a_back_idle", p_en, 1'b0);
    advance();

    // simultaneous requests: MEM store first, then IF
    if_req = 1; if_addr = 8'h44; mem_req = 1; mem_rw = 1; mem_size = 0;
    mem_addr = 8'h20; mem_wdata = 32'hDEADBEEF;
    settle();
    check_eq("b_stall0", if_stall, 1'b1);
    advance();
    p_rdy = 1; p_rdata = $urandom;
    settle();
    check_eq("b_mem_en", p_en, 1'b1);
    check_eq("b_mem_addr", p_addr, 8'h20);
    check_eq("b_wdata", p_wdata, 32'hDEADBEEF);
    check_eq("b_rw", p_rw, 1'b1);
    check_eq("b_stall1", if_stall, 1'b1);
    advance();
    mem_req = 0; mem_rw = 0; p_rdy = 0;
    settle();
    check_eq("b_idle", p_en, 1'b0);
    check_eq("b_stall2", if_stall, 1'b1);
    advance();
    settle();
    check_eq("b_if_en", p_en, 1'b1);
    check_eq("b_if_addr", p_addr, 8'h44);
    check_eq("b_stall3", if_stall, 1'b1);
    advance();
    p_rdy = 1;
    settle();
    check_eq("b_if_ack", if_ack, 1'b1);
    advance();
    if_req = 0; p_rdy = 0;
    cyc();

    // MEM access with five wait cycles
    mem_req = 1; mem_addr = 8'h30;
    cyc();
    for (int i = 0; i < 5; i++) begin
      settle();
      check_eq("c_wait_en", p_en, 1'b1);
      check_eq("c_wait_stall", mem_stall, 1'b1);
      check_eq("c_wait_ack", mem_ack, 1'b0);
      advance();
    end
    p_rdy = 1;
    settle();
    check_eq("c_ack6", mem_ack, 1'b1);
    check_eq("c_stall6", mem_stall, 1'b0);
    advance();
    mem_req = 0; p_rdy = 0;
    cyc();

    // requester withdraws mid-access
    mem_req = 1; mem_addr = 8'h31;
    cyc();
    mem_req = 0;
    cyc();
    p_rdy = 1;
    settle();
    check_eq("d_en", p_en, 1'b1);
    check_eq("d_no_ack", mem_ack, 1'b0);
    check_eq("d_rdata0", mem_rdata, 32'h0);
    advance();
    p_rdy = 0;
    settle();
    check_eq("d_idle", p_en, 1'b0);
    advance();

    // reset pulse in the middle of a MEM grant
    mem_req = 1; mem_addr = 8'h32;
    cyc();
    settle();
    check_eq("e_pre_en", p_en, 1'b1);
    p_rdy = 1; Clr = 1'b0;
    #1;
    check_eq("e_rst_en", p_en, 1'b0);
    check_eq("e_rst_ack", mem_ack, 1'b0);
    model_reset();
    @(posedge Clk);
    #1;
    Clr = 1'b1;
    cyc();
    settle();
    check_eq("e_regrant", p_en, 1'b1);
    check_eq("e_regrant_addr", p_addr, 8'h32);
    advance();
    mem_req = 0; p_rdy = 0;
    cyc();

    // continuous contention: grant order
    if_req = 1; if_addr = 8'h40; mem_req = 1; mem_addr = 8'h80; p_rdy = 1;
    gq.delete();
    for (int i = 0; i < 16; i++) begin
      settle();
      if (p_en) gq.push_back((p_addr == 8'h40) ? 1 : 2);
      advance();
    end
    check_eq("f_ngrants", gq.size(), 8);
    for (int k = 0; k < gq.size(); k++) begin
`ifdef ARB_FAIR_EN
      check_eq("f_gnt_fair", gq[k], ((k % 4) == 3) ? 1 : 2);
`else
      check_eq("f_gnt_strict", gq[k], 2);
`endif
    end
    if_req = 0; mem_req = 0; p_rdy = 0;
    cyc();

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if_req    = ($urandom_range(0, 3) != 0);
      mem_req   = ($urandom_range(0, 2) != 0);
      if_addr   = AW'($urandom);
      mem_addr  = AW'($urandom);
      mem_wdata = $urandom;
      mem_rw    = 1'($urandom);
      mem_size  = 1'($urandom);
      p_rdata   = $urandom;
      p_rdy     = ($urandom_range(0, 2) != 0);
      Clr       = ($urandom_range(0, 79) != 0);
      cyc();
    end
    Clr = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
